// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller and its bench.
package run_ctrl_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int MAX_CYCLES_DEF = 1000;
    localparam int DRAIN_CYC_DEF  = 1;
    localparam int DRAIN_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Program run sequencer: IDLE -> INIT -> RUN -> (DRAIN) -> DONE, with a
// watchdog on RUN length and a count of RUN cycles.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int DRAIN_CYC  = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_in,
    output logic             pc_init,
    output logic             run_en,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

    state_e               state_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 pc_init_q;
    logic                 run_en_q;
    logic                 done_q;
    logic                 timeout_q;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_W-1:0]     cnt_val;

    // The count is cleared on the edge that enters INIT, and also when an
    // illegal state is recovered so IDLE always shows a zero count.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: cnt_clr = start;
            ST_INIT, ST_DRAIN: cnt_clr = 1'b0;
            ST_RUN:           cnt_en  = 1'b1;
            default:          cnt_clr = 1'b1;
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .count_o(cnt_val)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            pc_init_q <= 1'b0;
            run_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pc_init_q <= 1'b0;
            run_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_INIT;
                        pc_init_q <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_INIT: begin
                    state_q  <= ST_RUN;
                    run_en_q <= 1'b1;
                end
                ST_RUN: begin
                    // A halt on the watchdog's last cycle still ends cleanly.
                    if (halt_in) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end else if (cnt_val == WD_LAST) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        run_en_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    drain_q   <= '0;
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_init     = pc_init_q;
    assign run_en      = run_en_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_val;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a directed vector table, a drain-latency sequence and
// randomized traffic against a behavioural model on two configurations.
module tb_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_in;
    logic        pci_a, run_a, done_a, to_a;
    logic [15:0] cnt_a;
    logic        pci_b, run_b, done_b, to_b;
    logic [7:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    run_ctrl #(.CNT_W(16), .MAX_CYCLES(8), .DRAIN_CYC(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .halt_in(halt_in),
        .pc_init(pci_a), .run_en(run_a), .done(done_a), .timeout(to_a),
        .cycle_count(cnt_a)
    );

    run_ctrl #(.CNT_W(8), .MAX_CYCLES(20), .DRAIN_CYC(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt_in(halt_in),
        .pc_init(pci_b), .run_en(run_b), .done(done_b), .timeout(to_b),
        .cycle_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, st, h;
        logic       pci, run, dn, to;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        int pci, run, dn, to, cnt, drain_left;
    } mdl_t;

    vec_t vecs[$];

    function automatic void add(input logic r, s, h, p, rn, d, t, input int c);
        vec_t v;
        v.rst = r; v.st = s; v.h = h;
        v.pci = p; v.run = rn; v.dn = d; v.to = t; v.cnt = 8'(c);
        vecs.push_back(v);
    endfunction

    // Reference: tracks what the controller is doing through its visible
    // outputs plus a count of remaining drain cycles.
    function automatic mdl_t mstep(input mdl_t m, input bit r, s, h,
                                   input int maxc, input int drn, input int cmax);
        mdl_t n = m;
        if (!r) begin
            n = '{default: 0};
            return n;
        end
        if (m.pci != 0) begin
            n.pci = 0;
            n.run = 1;
        end else if (m.run != 0) begin
            n.cnt = (m.cnt < cmax) ? m.cnt + 1 : m.cnt;
            n.run = 0;
            if (h) begin
                n.drain_left = drn;
            end else if (m.cnt == maxc - 1) begin
                n.dn = 1;
                n.to = 1;
            end else begin
                n.run = 1;
            end
        end else if (m.drain_left > 0) begin
            n.drain_left = m.drain_left - 1;
            if (n.drain_left == 0) n.dn = 1;
        end else if (s) begin
            n.pci = 1; n.dn = 0; n.to = 0; n.cnt = 0;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, s, h);
        reset = r; start = s; halt_in = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        mdl_t ma, mb;
        int   edges;
        reset = 1'b0; start = 1'b0; halt_in = 1'b0;

        // Directed table for the MAX_CYCLES=8, DRAIN_CYC=1 instance.
        add(0,0,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(1,1,0, 1,0,0,0,0);
        add(1,0,0, 0,1,0,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,0, 0,1,0,0,k);
        add(1,0,1, 0,0,0,0,5);
        add(1,0,0, 0,0,1,0,5);
        add(1,0,1, 0,0,1,0,5);
        add(1,1,0, 1,0,0,0,0);
        add(1,0,0, 0,1,0,0,0);
        for (int k = 1; k <= 7; k++) add(1, (k == 3), 0, 0,1,0,0,k);
        add(1,0,0, 0,0,1,1,8);
        add(1,0,0, 0,0,1,1,8);
        add(1,1,0, 1,0,0,0,0);
        add(1,0,0, 0,1,0,0,0);
        for (int k = 1; k <= 7; k++) add(1,0,0, 0,1,0,0,k);
        add(1,0,1, 0,0,0,0,8);
        add(1,0,0, 0,0,1,0,8);
        add(1,1,0, 1,0,0,0,0);
        add(1,0,0, 0,1,0,0,0);
        add(1,0,0, 0,1,0,0,1);
        add(1,0,0, 0,1,0,0,2);
        add(0,1,0, 0,0,0,0,0);
        add(0,1,1, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(1,0,1, 0,0,0,0,0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].h);
            $display("vec %0d: rst=%0b st=%0b h=%0b -> pci=%0b run=%0b done=%0b to=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].st, vecs[i].h, pci_a, run_a, done_a, to_a, cnt_a);
            chk("vec_pc_init", int'(pci_a),  int'(vecs[i].pci));
            chk("vec_run_en",  int'(run_a),  int'(vecs[i].run));
            chk("vec_done",    int'(done_a), int'(vecs[i].dn));
            chk("vec_timeout", int'(to_a),   int'(vecs[i].to));
            chk("vec_count",   int'(cnt_a),  int'(vecs[i].cnt));
        end

        // Drain latency with DRAIN_CYC=3: halt edge plus three drain edges.
        step(0,0,0);
        step(1,1,0);
        step(1,0,0);
        step(1,0,1);
        edges = 1;
        chk("drainB_run_dropped", int'(run_b), 0);
        while (!done_b && edges < 12) begin
            step(1,0,0);
            edges++;
            if (!done_b) chk("drainB_run_low", int'(run_b), 0);
        end
        $display("drainB: halt-to-done edges=%0d count=%0d timeout=%0b", edges, cnt_b, to_b);
        chk("drainB_latency", edges, 4);
        chk("drainB_count", int'(cnt_b), 1);
        chk("drainB_timeout", int'(to_b), 0);

        // Randomized traffic on both instances against the model.
        step(0,0,0);
        ma = '{default: 0};
        mb = '{default: 0};
        for (int i = 0; i < 800; i++) begin
            bit r, s, h;
            r = ($urandom_range(0, 39) != 0);
            s = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 9) == 0);
            step(r, s, h);
            ma = mstep(ma, r, s, h, 8, 1, 65535);
            mb = mstep(mb, r, s, h, 20, 3, 255);
            $display("rnd %0d: rst=%0b st=%0b h=%0b | A %0b%0b%0b%0b cnt=%0d | B %0b%0b%0b%0b cnt=%0d",
                     i, r, s, h, pci_a, run_a, done_a, to_a, cnt_a,
                     pci_b, run_b, done_b, to_b, cnt_b);
            chk("rndA_pc_init", int'(pci_a),  ma.pci);
            chk("rndA_run_en",  int'(run_a),  ma.run);
            chk("rndA_done",    int'(done_a), ma.dn);
            chk("rndA_timeout", int'(to_a),   ma.to);
            chk("rndA_count",   int'(cnt_a),  ma.cnt);
            chk("rndB_pc_init", int'(pci_b),  mb.pci);
            chk("rndB_run_en",  int'(run_b),  mb.run);
            chk("rndB_done",    int'(done_b), mb.dn);
            chk("rndB_timeout", int'(to_b),   mb.to);
            chk("rndB_count",   int'(cnt_b),  mb.cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
